// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: launch/result bundle between the CPU controller and the multiply/MAC unit
interface seq_multiplier_if #(parameter int WIDTH = 8);
    logic               start;
    logic               signed_mode;
    logic               acc;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] out;
    logic               ovf;
    modport master (output start, signed_mode, acc, in_a, in_b, input busy, done, out, ovf);
    modport slave  (input start, signed_mode, acc, in_a, in_b, output busy, done, out, ovf);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiply/MAC, one multiplier bit per clock
module seq_multiplier #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_n;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand, mplier, mag_a, mag_b;
    logic [2*WIDTH-1:0] prod, prod_s, out_r;
    logic [2*WIDTH:0]   sum;
    logic               neg, sgn, acc, done_r, ovf_r, ovf_n;
    // signed operands are reduced to magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
    always_comb begin
        mag_a   = (bus.signed_mode && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
        mag_b   = (bus.signed_mode && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
        prod_s  = neg ? -prod : prod;
        sum     = {1'b0, out_r} + {1'b0, prod_s};
        ovf_n   = !acc ? 1'b0
                : sgn  ? (out_r[2*WIDTH-1] == prod_s[2*WIDTH-1]) && (sum[2*WIDTH-1] != out_r[2*WIDTH-1])
                :        sum[2*WIDTH];
        state_n = (state == IDLE && bus.start) ? RUN
                : (state == RUN && cnt == LAST) ? FIX
                : (state == FIX)                ? IDLE
                :                                 state;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            neg    <= 1'b0;
            sgn    <= 1'b0;
            acc    <= 1'b0;
            out_r  <= '0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state == FIX);
            if (state == IDLE && bus.start) begin
                mcand  <= mag_a;
                mplier <= mag_b;
                neg    <= bus.signed_mode && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                sgn    <= bus.signed_mode;
                acc    <= bus.acc;
                prod   <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                if (mplier[0]) prod <= prod + ({{WIDTH{1'b0}}, mcand} << cnt);
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end else if (state == FIX) begin
                out_r <= acc ? sum[2*WIDTH-1:0] : prod_s;
                ovf_r <= ovf_n;
            end
        end
    end
    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.out  = out_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Iterative shift-add multiplier, parametrised in operand width. Processes one multiplier bit per clock.
- Adds a start/busy/done handshake, a signed (two's-complement) mode, and an accumulate mode with overflow flag.
- Sits beside the ALU as the CPU's multiply/MAC execution unit. The controller launches an operation and waits for DONE instead of relying on a wide combinational path.

Parameters:
WIDTH, 8, operand width in bits (legal range 2..32); result width is 2*WIDTH

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous, active-high reset
START  input  1  launch request, sampled on rising CLK while idle
SIGNED_MODE  input  1  sampled with START; 1 = two's-complement operands, 0 = unsigned
ACC  input  1  sampled with START; 1 = OUT_new = OUT_old + product, 0 = OUT_new = product
IN_A  input  WIDTH  multiplicand, sampled with START
IN_B  input  WIDTH  multiplier, sampled with START
BUSY  output  1  high while an operation is in progress
DONE  output  1  one-cycle pulse when OUT is updated
OUT  output  2*WIDTH  result register, held until the next completion
OVF  output  1  accumulate overflow flag, updated at each completion

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state IDLE; OUT=0, OVF=0, BUSY=0, DONE=0; internal registers cleared.
  - An in-flight operation is discarded and never completes.
- States:
  - IDLE -> RUN on START=1.
  - RUN -> FIX after WIDTH RUN cycles.
  - FIX -> IDLE unconditionally.
- IDLE, START=1 at edge k:
  - Capture SIGNED_MODE, ACC, IN_A, IN_B.
  - In signed mode, store operand magnitudes plus result sign = sign(A) XOR sign(B). Magnitude of the most negative value is 2^(WIDTH-1), held unsigned.
  - Clear the partial product; bit counter = 0; BUSY=1 from edge k.
- RUN (edges k+1 .. k+WIDTH):
  - If the current LSB of the shifted multiplier magnitude is 1, add (multiplicand magnitude << counter) into the 2*WIDTH partial product.
  - Shift the multiplier right; increment the counter.
  - No overflow is possible inside the product: WIDTH x WIDTH fits in 2*WIDTH bits.
- FIX (edge k+WIDTH+1):
  - Negate the partial product if signed mode and result sign = 1.
  - If ACC=0: OUT <= product, OVF <= 0.
  - If ACC=1: OUT <= OUT + product, mod 2^(2*WIDTH).
    - Unsigned mode: OVF <= carry out of bit 2*WIDTH-1.
    - Signed mode: OVF <= 1 when both addends share a sign and the sum's sign differs.
  - DONE=1 for exactly this one cycle; BUSY=0; state IDLE.
- Latency: DONE is high during the cycle after edge k+WIDTH+1, i.e. WIDTH+2 edges from the START sample.
- Handshake:
  - START while BUSY=1 is ignored; captured operands are unaffected.
  - START held high during the DONE cycle is accepted as a new launch, giving back-to-back throughput of one result per WIDTH+2 cycles.
- Operand inputs may change freely after the START sample.
- OUT and OVF change only at a FIX edge or on reset; they are stable otherwise.
- Zero operands take full latency; there is no early termination.
- BUSY and DONE are never high simultaneously.

Test Plan:
- WIDTH=8, unsigned, A=255, B=255, ACC=0 -> DONE exactly 10 edges after START sample; OUT=0xFE01, OVF=0, BUSY high for 9 cycles.
- Signed cases:
  - A=0x80 (-128), B=0x80 -> OUT=0x4000.
  - A=0x80, B=0x7F -> OUT=0xC080.
  - A=0xFF (-1), B=0x01 -> OUT=0xFFFF.
- Accumulate:
  - After OUT=0xFE01, unsigned ACC=1 with 255*255 -> OUT=0xFC02, OVF=1.
  - Then ACC=0 with 3*4 -> OUT=0x000C, OVF=0.
- Signed accumulate overflow: OUT=0x4000 (from -128*-128), then ACC=1 with -128*-128 -> OUT=0x8000, OVF=1.
- Handshake:
  - Pulse START mid-RUN with different operands -> ignored; the original result is delivered.
  - Hold START high through DONE -> second operation launches in the DONE cycle; its DONE arrives 10 edges later.
- Reset at RUN cycle 4 with OUT previously 0x1234 -> OUT=0, BUSY=0, DONE never pulses; a new START afterwards completes normally (7*9 -> 0x003F).
